// File: rtl/interp_stream_filter.sv
// interp_stream_filter
//   Streaming 8-tap interpolation filter. The three results are the quarter,
//   half and three-quarter phase sums, each computed over a sliding window of
//   the last eight accepted samples.
//
// Parameters
//   DATA_W    unsigned sample width (4..16)
//   SHORT_EN  0 disables mode[0] (short variants never used)
//   SIMPLE_EN 0 disables mode[1] (simple variants never used)
//
// Ports
//   clock, reset_L          rising-edge clock, async active-low reset
//   flush                   synchronous clear of window, count and pending result
//   mode[1:0]               bit0 short (drop +/-1 taps), bit1 simple coefficients
//   in_valid/in_data/in_ready    sample handshake
//   out_valid/out_ready          result handshake
//   out_a/out_b/out_c       signed raw filter sums (ACC_W bits)
//   px_a/px_b/px_c          rounded, clipped pixels (DATA_W bits)
module interp_stream_filter #(
  parameter int DATA_W    = 8,
  parameter int SHORT_EN  = 1,
  parameter int SIMPLE_EN = 1,
  localparam int ACC_W    = DATA_W + 8
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    flush,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_a,
  output logic signed [ACC_W-1:0] out_b,
  output logic signed [ACC_W-1:0] out_c,
  output logic [DATA_W-1:0]       px_a,
  output logic [DATA_W-1:0]       px_b,
  output logic [DATA_W-1:0]       px_c
);

  // Coefficient tables, one row per phase (A, B, C), each listed w7..w0.
  localparam int EXACT [3][7:0] = '{
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };
  localparam int SIMPLE [3][7:0] = '{
    '{-1, 4, -8, 64, 16, -4, 1,  0},
    '{-1, 4, -8, 32, 32, -8, 4, -1},
    '{ 0, 1, -4, 16, 64, -8, 4, -1}
  };

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(32);
  localparam logic signed [ACC_W-1:0] PX_MAX = ACC_W'((1 << DATA_W) - 1);

  // Constant multiply as shift/add; k is always a table constant, so each
  // call folds down to the matching adder tree.
  function automatic logic signed [ACC_W-1:0] mul_k(
    input logic signed [ACC_W-1:0] x,
    input int                      k
  );
    logic signed [ACC_W-1:0] p;
    int                      m;
    m = (k < 0) ? -k : k;
    case (m)
      1:       p = x;
      4:       p = x <<< 2;
      5:       p = (x <<< 2) + x;
      8:       p = x <<< 3;
      10:      p = (x <<< 3) + (x <<< 1);
      11:      p = (x <<< 3) + (x <<< 1) + x;
      16:      p = x <<< 4;
      17:      p = (x <<< 4) + x;
      32:      p = x <<< 5;
      40:      p = (x <<< 5) + (x <<< 3);
      58:      p = (x <<< 6) - (x <<< 2) - (x <<< 1);
      64:      p = x <<< 6;
      default: p = '0;
    endcase
    return (k < 0) ? -p : p;
  endfunction

  function automatic logic [DATA_W-1:0] clip_px(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> 6;
    if (r[ACC_W-1])     return '0;
    else if (r > PX_MAX) return '1;
    else                return r[DATA_W-1:0];
  endfunction

  logic [7:0][DATA_W-1:0]  win_q, win_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_a_q, out_a_d;
  logic signed [ACC_W-1:0] out_b_q, out_b_d;
  logic signed [ACC_W-1:0] out_c_q, out_c_d;

  logic                    xfer;
  logic                    short_sel, simple_sel;
  logic signed [ACC_W-1:0] full_ex [3];
  logic signed [ACC_W-1:0] unit_ex [3];
  logic signed [ACC_W-1:0] full_si [3];
  logic signed [ACC_W-1:0] unit_si [3];
  logic signed [ACC_W-1:0] res     [3];

  assign short_sel  = (SHORT_EN != 0) && mode[0];
  assign simple_sel = (SIMPLE_EN != 0) && mode[1];

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  // Post-shift window: newest sample enters at w7.
  always_comb begin
    win_d = win_q;
    if (flush)     win_d = '0;
    else if (xfer) win_d = {in_data, win_q[7:1]};
  end

  // Short variants are formed as full sum minus the +/-1 tap contribution,
  // so only two sums per phase are built instead of four.
  always_comb begin
    logic signed [ACC_W-1:0] x;
    for (int unsigned f = 0; f < 3; f++) begin
      full_ex[f] = '0;
      unit_ex[f] = '0;
      full_si[f] = '0;
      unit_si[f] = '0;
      for (int unsigned i = 0; i < 8; i++) begin
        x = signed'({8'h00, win_d[i]});
        full_ex[f] = full_ex[f] + mul_k(x, EXACT[f][i]);
        full_si[f] = full_si[f] + mul_k(x, SIMPLE[f][i]);
        if (EXACT[f][i] == 1 || EXACT[f][i] == -1)
          unit_ex[f] = unit_ex[f] + mul_k(x, EXACT[f][i]);
        if (SIMPLE[f][i] == 1 || SIMPLE[f][i] == -1)
          unit_si[f] = unit_si[f] + mul_k(x, SIMPLE[f][i]);
      end
      if (simple_sel) res[f] = short_sel ? (full_si[f] - unit_si[f]) : full_si[f];
      else            res[f] = short_sel ? (full_ex[f] - unit_ex[f]) : full_ex[f];
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    if (flush) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (xfer) begin
        cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
        if (cnt_q >= 4'd7) begin
          out_valid_d = 1'b1;
          out_a_d     = res[0];
          out_b_d     = res[1];
          out_c_d     = res[2];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      win_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
    end else begin
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign px_a      = clip_px(out_a_q);
  assign px_b      = clip_px(out_b_q);
  assign px_c      = clip_px(out_c_q);

endmodule

// File: tb/tb_interp_stream_filter.sv
// tb_interp_stream_filter
//   Directed bench for interp_stream_filter at DATA_W = 8 (ACC_W = 16).
//   Inputs are driven 1 ns after the rising edge; registered outputs are
//   sampled at that point, combinational in_ready 1 ns later.
module tb_interp_stream_filter;

  logic               clock;
  logic               reset_L;
  logic               flush;
  logic [1:0]         mode;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_a, out_b, out_c;
  logic [7:0]         px_a, px_b, px_c;

  int checks = 0;
  int errors = 0;

  interp_stream_filter #(.DATA_W(8), .SHORT_EN(1), .SIMPLE_EN(1)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .flush     (flush),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .px_a      (px_a),
    .px_b      (px_b),
    .px_c      (px_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transfer: present a sample, take the edge, land 1 ns after it.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset_L   = 1'b0;
    flush     = 1'b0;
    mode      = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_px_b", px_b, 0);
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Fill with constant 100, exact mode.
    for (int i = 0; i < 7; i++) begin
      send(8'd100);
      chk("fill_no_valid", out_valid, 0);
    end
    send(8'd100);
    chk("exact_valid", out_valid, 1);
    chk("exact_a", out_a, 6400);
    chk("exact_b", out_b, 6400);
    chk("exact_c", out_c, 6400);
    chk("exact_px_a", px_a, 100);
    chk("exact_px_c", px_c, 100);

    // Mode changes apply to the next transfer; window kept.
    mode = 2'd2;
    send(8'd100);
    chk("simple_a", out_a, 7200);
    chk("simple_b", out_b, 5400);
    chk("simple_c", out_c, 7200);
    chk("simple_px_a", px_a, 113);
    chk("simple_px_b", px_b, 84);
    chk("simple_px_c", px_c, 113);

    mode = 2'd3;
    send(8'd100);
    chk("ss_a", out_a, 7200);
    chk("ss_b", out_b, 5600);
    chk("ss_c", out_c, 7200);

    // Exact short: B loses its two -1 end taps, so its gain becomes 66.
    mode = 2'd1;
    send(8'd100);
    chk("es_a", out_a, 6400);
    chk("es_b", out_b, 6600);
    chk("es_c", out_c, 6400);

    // Flush with a sample presented: sample dropped, result cleared.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);

    // Impulse of 255 landing at w4, exact mode.
    mode = 2'd0;
    send(8'd0); send(8'd0); send(8'd0); send(8'd0);
    send(8'd255); send(8'd0); send(8'd0);
    chk("refill_no_valid", out_valid, 0);
    send(8'd0);
    chk("imp4_valid", out_valid, 1);
    chk("imp4_a", out_a, 14790);
    chk("imp4_px_a", px_a, 231);
    chk("imp4_b", out_b, 10200);
    chk("imp4_px_b", px_b, 159);
    chk("imp4_c", out_c, 4335);
    chk("imp4_px_c", px_c, 68);

    // Impulse landing at w5.
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush2_out_valid", out_valid, 0);
    send(8'd0); send(8'd0); send(8'd0); send(8'd0);
    send(8'd0); send(8'd255); send(8'd0); send(8'd0);
    chk("imp5_a", out_a, -2550);
    chk("imp5_px_a", px_a, 0);
    chk("imp5_b", out_b, -2805);
    chk("imp5_c", out_c, -1275);

    // Backpressure: hold out_ready low for 3 cycles with a sample waiting.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      @(posedge clock);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_hold_a", out_a, -2550);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    chk("rel_valid", out_valid, 1);
    chk("rel_a", out_a, 14780);
    chk("rel_b", out_b, 10190);
    in_data = 8'd20;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_a", out_a, 4355);
    @(posedge clock);
    #1;
    chk("drain_valid", out_valid, 0);

    // Asynchronous reset mid-cycle with a result pending.
    send(8'd30);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_a", out_a, 0);
    chk("async_rst_c", out_c, 0);
    chk("async_rst_px_a", px_a, 0);
    reset_L = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) send(8'd100);
    chk("rst2_no_valid", out_valid, 0);
    send(8'd100);
    chk("rst2_valid", out_valid, 1);
    chk("rst2_b", out_b, 6400);
    chk("rst2_px_b", px_b, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
